// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: one state per cycle, outputs combinational from state and instruction fields.
// Latency 2-5 cycles per instruction (FETCH to FETCH); no backpressure, a strictly self-timed sequence.
module multicycle_controller #(
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic                  reg_write,
    output logic [1:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  instr_done,
    output logic                  illegal_instr
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] JAL      = 4'd9;
    localparam logic [3:0] BEQ      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

    logic [3:0] state_q;
    logic [3:0] state_d;

    logic [1:0] alu_op;
    logic       pc_write_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       instr_done_raw;
    logic       illegal_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // Strobes are computed raw here and gated by reset below, so a reset
    // in any state suppresses writes in that same cycle.
    always_comb begin
        pc_write_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        ir_write_raw   = 1'b0;
        reg_write_raw  = 1'b0;
        instr_done_raw = 1'b0;
        illegal_raw    = 1'b0;
        adr_src        = 1'b0;
        result_src     = 2'b00;
        alu_src_a      = 2'b00;
        alu_src_b      = 2'b00;
        alu_op         = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (op != OP_LW && op != OP_SW && op != OP_R && op != OP_I &&
                    op != OP_JAL && op != OP_BEQ) begin
                    illegal_raw    = 1'b1;
                    instr_done_raw = 1'b1;
                end
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src     = 2'b01;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            MEMWRITE: begin
                adr_src        = 1'b1;
                mem_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNC;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNC;
            end
            ALUWB: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            JAL: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write_raw = 1'b1;
            end
            BEQ: begin
                alu_src_a      = 2'b10;
                alu_op         = ALUOP_SUB;
                pc_write_raw   = zero;
                instr_done_raw = 1'b1;
            end
            default: begin
                pc_write_raw = 1'b0;
            end
        endcase
    end

    // funct7b5 only selects sub for R-type; addi reuses funct3 000 without it.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign pc_write      = pc_write_raw   & ~reset;
    assign mem_write     = mem_write_raw  & ~reset;
    assign ir_write      = ir_write_raw   & ~reset;
    assign reg_write     = reg_write_raw  & ~reset;
    assign instr_done    = instr_done_raw & ~reset;
    assign illegal_instr = illegal_raw    & ~reset;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core: sequences the shared ALU, register file, instruction register and unified memory through fetch, decode, execute and writeback.
- Decodes op/funct3/funct7b5 from the instruction register into a 3-bit ALU control word:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt
- Drives every datapath mux select and write strobe, one instruction at a time.

Parameters:
ALU_CTRL_W, 3, width of alu_control; fixed at 3, do not override

Ports:
clk  input  1  single clock, all state changes on rising edge
reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
op  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag, valid in the BEQ state
pc_write  output  1  PC register enable
adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register and old-PC enable
result_src  output  2  result mux select: 00 = ALUOut, 01 = data register, 10 = ALU result
alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1 data
alu_src_b  output  2  ALU B select: 00 = rs2 data, 01 = immediate, 10 = constant 4
reg_write  output  1  register file write enable
imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
alu_control  output  3  ALU operation code
instr_done  output  1  one-cycle pulse in the final state of each instruction
illegal_instr  output  1  one-cycle pulse in DECODE when the opcode is unsupported

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ. Registered state; all outputs are combinational from state and the instruction fields.
- Reset: while reset is high at a clock edge, next state = FETCH. While reset is high, every strobe (pc_write, mem_write, ir_write, reg_write, instr_done, illegal_instr) is forced to 0. Reset mid-instruction abandons that instruction with no further writes.
- ALUOp (internal):
  - 00 gives add.
  - 01 gives sub.
  - 10 decodes funct3:
    - 000: sub if op[5] & funct7b5, else add. addi ignores funct7b5.
    - 010: slt.
    - 110: or.
    - 111: and.
    - Any other funct3: add.
- Per state (unlisted selects = 00, unlisted strobes = 0):
  - FETCH: adr_src 0, ir_write 1, alu_src_a 00, alu_src_b 10, ALUOp 00, result_src 10, pc_write 1. Next: DECODE.
  - DECODE: alu_src_a 01, alu_src_b 01, ALUOp 00 (branch target). Next state by op:
    - 0000011 or 0100011: MEMADR.
    - 0110011: EXECUTER.
    - 0010011: EXECUTEI.
    - 1101111: JAL.
    - 1100011: BEQ.
    - Otherwise: FETCH, with illegal_instr = 1 and instr_done = 1.
  - MEMADR: alu_src_a 10, alu_src_b 01, ALUOp 00. Next: MEMREAD if op[5] = 0, else MEMWRITE.
  - MEMREAD: adr_src 1, result_src 00. Next: MEMWB.
  - MEMWB: result_src 01, reg_write 1, instr_done 1. Next: FETCH.
  - MEMWRITE: adr_src 1, mem_write 1, instr_done 1. Next: FETCH.
  - EXECUTER: alu_src_a 10, alu_src_b 00, ALUOp 10. Next: ALUWB.
  - EXECUTEI: alu_src_a 10, alu_src_b 01, ALUOp 10. Next: ALUWB.
  - ALUWB: result_src 00, reg_write 1, instr_done 1. Next: FETCH.
  - JAL: alu_src_a 01, alu_src_b 10, ALUOp 00, result_src 00, pc_write 1. Next: ALUWB.
  - BEQ: alu_src_a 10, alu_src_b 00, ALUOp 01, result_src 00, pc_write = zero, instr_done 1. Next: FETCH.
- imm_src is decoded from op in every state:
  - I (00) for lw and I-ALU.
  - S (01) for sw.
  - B (10) for beq.
  - J (11) for jal.
  - 00 otherwise.
- Cycles from FETCH to FETCH, inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - I-ALU 4
  - jal 4
  - beq 3
  - illegal 2
- pc_write is asserted at most once per state. It is never asserted in the same cycle as mem_write.

Test Plan:
- Reset held 3 cycles, then released → state FETCH; first cycle has ir_write = 1, pc_write = 1, alu_src_b = 10, alu_control = 000; all strobes stayed 0 during reset.
- lw (op 0000011, funct3 010) → 5 cycles: FETCH, DECODE, MEMADR (alu_control 000, alu_src_b 01), MEMREAD (adr_src 1), MEMWB (result_src 01, reg_write 1, instr_done 1).
- sub (op 0110011, funct3 000, funct7b5 1) → EXECUTER alu_control = 001. addi with funct7b5 = 1 (op 0010011) → EXECUTEI alu_control = 000. slt/or/and (funct3 010/110/111) → alu_control 101/011/010.
- beq with zero = 1 → BEQ cycle pc_write = 1, alu_control = 001. Same with zero = 0 → pc_write = 0. Both cases total 3 cycles.
- jal (op 1101111) → JAL cycle pc_write 1, alu_src_a 01, alu_src_b 10; then ALUWB reg_write 1; imm_src = 11 throughout.
- Illegal op 0000000 → DECODE asserts illegal_instr = 1, then returns to FETCH with no reg_write or mem_write. Reset asserted during MEMWRITE's preceding MEMADR cycle → no mem_write ever asserted; next state FETCH.
